// File: rtl/ooo_pkg.sv
// ---------------------------------------------------------------------------
// ooo_pkg
//   Shared widths and types for the ALU reservation station.
//   RS_N_ENTRIES : default station depth
//   TAG_W        : ROB tag width (matches the CDB tag)
//   DATA_W       : operand / result width
//   OP_W         : ALU opcode width
//   rs_src_t     : one source operand slot {rdy, tag, val}
//   rs_entry_t   : one station entry {valid, op, dst_tag, s1, s2}
// ---------------------------------------------------------------------------
package ooo_pkg;

  localparam int RS_N_ENTRIES = 4;
  localparam int TAG_W        = 6;
  localparam int DATA_W       = 32;
  localparam int OP_W         = 4;

  typedef struct packed {
    logic              rdy;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
  } rs_src_t;

  typedef struct packed {
    logic             valid;
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] dst_tag;
    rs_src_t          s1;
    rs_src_t          s2;
  } rs_entry_t;

  // A CDB broadcast matches a waiting operand on an exact tag compare.
  function automatic logic cdb_hit(input logic             bus_valid,
                                   input logic [TAG_W-1:0] bus_tag,
                                   input logic [TAG_W-1:0] src_tag);
    return bus_valid && (bus_tag == src_tag);
  endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// ---------------------------------------------------------------------------
// rs_age_matrix
//   Tracks relative age of station entries and picks the oldest requester.
//   clk, rst_n : clock, synchronous active-low reset
//   i_flush    : clear all age information
//   i_valid    : entry occupancy before this edge
//   i_alloc    : one-hot entry being allocated this edge
//   i_free     : one-hot entry being released this edge
//   i_req      : entries requesting selection
//   o_grant    : one-hot oldest requester (zero when no request)
// ---------------------------------------------------------------------------
module rs_age_matrix #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic [N-1:0] i_valid,
  input  logic [N-1:0] i_alloc,
  input  logic [N-1:0] i_free,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_grant
);

  // r_older[i][j] set means entry j is older than entry i.
  logic [N-1:0] r_older [N];

  // NOTE: sequential state uses non-blocking assignments so every bit sees
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      for (int i = 0; i < N; i++) r_older[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          // A departing entry is older than nobody any more; this also wins
          // over a same-edge allocation that would record it as older.
          if (i_free[j])      r_older[i][j] <= 1'b0;
          else if (i_alloc[i]) r_older[i][j] <= i_valid[j];
        end
      end
    end
  end

  // NOTE: combinational outputs get a full default first so no path can
  // leave a bit unassigned and infer a latch.
  always_comb begin
    o_grant = '0;
    for (int i = 0; i < N; i++) o_grant[i] = i_req[i] & ~|(i_req & r_older[i]);
  end

endmodule

// File: rtl/alu_reservation_station.sv
// ---------------------------------------------------------------------------
// alu_reservation_station
//   Holds dispatched ALU ops until both operands are available, wakes them
//   from the CDB and issues the oldest ready op into a registered issue slot.
//   clk, rst_n       : clock, synchronous active-low reset
//   flush            : squash all entries and the issue slot
//   disp_*           : dispatch request / operands; disp_ready = not full
//   cdb_valid/tag/data : common data bus broadcast snooped for wakeup
//   alu_stall        : ALU cannot take a new op; issue slot holds
//   iss_*            : registered issue to the ALU
// ---------------------------------------------------------------------------
module alu_reservation_station
  import ooo_pkg::*;
#(
  parameter int N_ENTRIES = RS_N_ENTRIES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [OP_W-1:0]   disp_op,
  input  logic [TAG_W-1:0]  disp_dst_tag,
  input  logic              disp_s1_rdy,
  input  logic [TAG_W-1:0]  disp_s1_tag,
  input  logic [DATA_W-1:0] disp_s1_val,
  input  logic              disp_s2_rdy,
  input  logic [TAG_W-1:0]  disp_s2_tag,
  input  logic [DATA_W-1:0] disp_s2_val,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              alu_stall,
  output logic              iss_valid,
  output logic [OP_W-1:0]   iss_op,
  output logic [TAG_W-1:0]  iss_dst_tag,
  output logic [DATA_W-1:0] iss_a,
  output logic [DATA_W-1:0] iss_b
);

  rs_entry_t r_ent [N_ENTRIES];

  logic              r_iss_valid;
  logic [OP_W-1:0]   r_iss_op;
  logic [TAG_W-1:0]  r_iss_dst_tag;
  logic [DATA_W-1:0] r_iss_a;
  logic [DATA_W-1:0] r_iss_b;

  logic [N_ENTRIES-1:0] w_valid, w_eligible, w_grant, w_slot_oh, w_alloc_oh, w_free_oh;
  rs_entry_t            w_sel;
  rs_src_t              w_disp_s1, w_disp_s2;
  logic                 w_advance, w_disp_fire, w_direct;

  always_comb begin
    w_valid    = '0;
    w_eligible = '0;
    w_sel      = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      w_valid[i]    = r_ent[i].valid;
      w_eligible[i] = r_ent[i].valid & r_ent[i].s1.rdy & r_ent[i].s2.rdy;
      if (w_grant[i]) w_sel = r_ent[i];
    end
  end

  // Full/empty comes from registered occupancy only, so a slot freed this
  // edge is not offered to dispatch until the next cycle.
  assign disp_ready = ~&w_valid;

  // Isolate the lowest clear bit of the occupancy vector.
  assign w_slot_oh = ~w_valid & (w_valid + {{(N_ENTRIES-1){1'b0}}, 1'b1});

  // Dispatch-time operands, with same-cycle CDB bypass for waiting sources.
  always_comb begin
    w_disp_s1.tag = disp_s1_tag;
    w_disp_s1.rdy = disp_s1_rdy | cdb_hit(cdb_valid, cdb_tag, disp_s1_tag);
    w_disp_s1.val = disp_s1_rdy ? disp_s1_val : cdb_data;
    w_disp_s2.tag = disp_s2_tag;
    w_disp_s2.rdy = disp_s2_rdy | cdb_hit(cdb_valid, cdb_tag, disp_s2_tag);
    w_disp_s2.val = disp_s2_rdy ? disp_s2_val : cdb_data;
  end

  assign w_advance   = !r_iss_valid || !alu_stall;
  assign w_disp_fire = disp_valid && disp_ready && !flush;
  // A fully ready dispatch goes straight to the issue slot when nothing
  // already in the station is eligible; it can never overtake an older op.
  assign w_direct    = w_disp_fire && w_disp_s1.rdy && w_disp_s2.rdy &&
                       w_advance && !(|w_eligible);
  assign w_alloc_oh  = (w_disp_fire && !w_direct) ? w_slot_oh : '0;
  assign w_free_oh   = w_advance ? w_grant : '0;

  rs_age_matrix #(.N(N_ENTRIES)) u_age (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_valid (w_valid),
    .i_alloc (w_alloc_oh),
    .i_free  (w_free_oh),
    .i_req   (w_eligible),
    .o_grant (w_grant)
  );

  // NOTE: only the valid bits are reset; payload fields are don't-care
  // while an entry is invalid and are always written on allocation.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int i = 0; i < N_ENTRIES; i++) r_ent[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (w_alloc_oh[i]) begin
          r_ent[i] <= '{valid: 1'b1, op: disp_op, dst_tag: disp_dst_tag,
                        s1: w_disp_s1, s2: w_disp_s2};
        end else begin
          if (w_free_oh[i]) r_ent[i].valid <= 1'b0;
          if (r_ent[i].valid && !r_ent[i].s1.rdy &&
              cdb_hit(cdb_valid, cdb_tag, r_ent[i].s1.tag)) begin
            r_ent[i].s1.rdy <= 1'b1;
            r_ent[i].s1.val <= cdb_data;
          end
          if (r_ent[i].valid && !r_ent[i].s2.rdy &&
              cdb_hit(cdb_valid, cdb_tag, r_ent[i].s2.tag)) begin
            r_ent[i].s2.rdy <= 1'b1;
            r_ent[i].s2.val <= cdb_data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_iss_valid   <= 1'b0;
      r_iss_op      <= '0;
      r_iss_dst_tag <= '0;
      r_iss_a       <= '0;
      r_iss_b       <= '0;
    end else if (flush) begin
      r_iss_valid <= 1'b0;
    end else if (w_advance) begin
      if (|w_grant) begin
        r_iss_valid   <= 1'b1;
        r_iss_op      <= w_sel.op;
        r_iss_dst_tag <= w_sel.dst_tag;
        r_iss_a       <= w_sel.s1.val;
        r_iss_b       <= w_sel.s2.val;
      end else if (w_direct) begin
        r_iss_valid   <= 1'b1;
        r_iss_op      <= disp_op;
        r_iss_dst_tag <= disp_dst_tag;
        r_iss_a       <= w_disp_s1.val;
        r_iss_b       <= w_disp_s2.val;
      end else begin
        r_iss_valid <= 1'b0;
      end
    end
  end

  assign iss_valid   = r_iss_valid;
  assign iss_op      = r_iss_op;
  assign iss_dst_tag = r_iss_dst_tag;
  assign iss_a       = r_iss_a;
  assign iss_b       = r_iss_b;

endmodule

// File: tb/tb_alu_reservation_station.sv
// ---------------------------------------------------------------------------
// tb_alu_reservation_station
//   Directed bench for alu_reservation_station. Expected issues are queued
//   as stimulus is driven; a monitor pops and compares each issue the ALU
//   accepts. Inputs change 1ns after the rising edge; outputs are read then
//   or on the falling edge.
// ---------------------------------------------------------------------------
module tb_alu_reservation_station;
  import ooo_pkg::*;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  dst;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } exp_t;

  logic              clk, rst_n, flush;
  logic              disp_valid, disp_ready;
  logic [OP_W-1:0]   disp_op;
  logic [TAG_W-1:0]  disp_dst_tag, disp_s1_tag, disp_s2_tag;
  logic              disp_s1_rdy, disp_s2_rdy;
  logic [DATA_W-1:0] disp_s1_val, disp_s2_val;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              alu_stall;
  logic              iss_valid;
  logic [OP_W-1:0]   iss_op;
  logic [TAG_W-1:0]  iss_dst_tag;
  logic [DATA_W-1:0] iss_a, iss_b;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  alu_reservation_station #(.N_ENTRIES(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_dst_tag(disp_dst_tag),
    .disp_s1_rdy(disp_s1_rdy), .disp_s1_tag(disp_s1_tag), .disp_s1_val(disp_s1_val),
    .disp_s2_rdy(disp_s2_rdy), .disp_s2_tag(disp_s2_tag), .disp_s2_val(disp_s2_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .alu_stall(alu_stall),
    .iss_valid(iss_valid), .iss_op(iss_op), .iss_dst_tag(iss_dst_tag),
    .iss_a(iss_a), .iss_b(iss_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic drive_disp(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] dst,
                            input logic r1, input logic [TAG_W-1:0] t1, input logic [DATA_W-1:0] v1,
                            input logic r2, input logic [TAG_W-1:0] t2, input logic [DATA_W-1:0] v2);
    disp_valid   = 1'b1;
    disp_op      = op;
    disp_dst_tag = dst;
    disp_s1_rdy  = r1; disp_s1_tag = t1; disp_s1_val = v1;
    disp_s2_rdy  = r2; disp_s2_tag = t2; disp_s2_val = v2;
  endtask

  task automatic drive_cdb(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_data  = data;
  endtask

  task automatic push_exp(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] dst,
                          input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    sb_q.push_back('{op: op, dst: dst, a: a, b: b});
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (sb_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check("drain", 128'(sb_q.size()), 128'(0));
  endtask

  // An issue is taken by the ALU at the next rising edge when it is valid,
  // not stalled and not flushed.
  always @(negedge clk) begin
    if (rst_n && iss_valid && !alu_stall && !flush) begin
      check("sb_underflow", 128'(sb_q.size() != 0), 128'(1));
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("issue", {iss_op, iss_dst_tag, iss_a, iss_b}, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; alu_stall = 1'b0;
    idle();
    drive_disp('0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    disp_valid = 1'b0;
    cdb_tag = '0; cdb_data = '0;
    tick(); tick();
    check("rst_iss_valid", 128'(iss_valid), 128'(0));
    rst_n = 1'b1;
    tick();
    check("rst_disp_ready", 128'(disp_ready), 128'(1));
    check("rst_iss_valid2", 128'(iss_valid), 128'(0));
    check("rst_iss_data", {iss_op, iss_dst_tag, iss_a, iss_b}, 128'(0));

    // 1: both sources ready, empty station -> issue the next cycle
    drive_disp(4'h1, 6'd3, 1'b1, '0, 32'd5, 1'b1, '0, 32'd7);
    push_exp(4'h1, 6'd3, 32'd5, 32'd7);
    tick(); idle();
    check("t1_iss_valid", 128'(iss_valid), 128'(1));
    check("t1_iss_a", 128'(iss_a), 128'(5));
    check("t1_iss_b", 128'(iss_b), 128'(7));
    check("t1_iss_dst", 128'(iss_dst_tag), 128'(3));
    tick();
    check("t1_iss_idle", 128'(iss_valid), 128'(0));

    // 2: src1 waits on tag 9, CDB two cycles later -> issue at wakeup+2
    drive_disp(4'h2, 6'd5, 1'b0, 6'd9, '0, 1'b1, '0, 32'd2);
    tick(); idle();
    tick();
    drive_cdb(6'd9, 32'h10);
    push_exp(4'h2, 6'd5, 32'h10, 32'd2);
    tick(); idle();
    check("t2_not_yet", 128'(iss_valid), 128'(0));
    tick();
    check("t2_iss_valid", 128'(iss_valid), 128'(1));
    check("t2_iss_a", 128'(iss_a), 128'h10);
    tick();

    // 3: CDB hits the waiting tag in the dispatch cycle
    drive_disp(4'h3, 6'd6, 1'b0, 6'd4, '0, 1'b1, '0, 32'd1);
    drive_cdb(6'd4, 32'hAA);
    push_exp(4'h3, 6'd6, 32'hAA, 32'd1);
    tick(); idle();
    check("t3_iss_valid", 128'(iss_valid), 128'(1));
    check("t3_iss_a", 128'(iss_a), 128'hAA);
    tick();

    // 4: fill the station, fifth dispatch ignored, one issue frees a slot
    for (int k = 0; k < 4; k++) begin
      drive_disp(4'h4, TAG_W'(10 + k), 1'b0, TAG_W'(40 + k), '0, 1'b1, '0, DATA_W'(k));
      tick();
    end
    idle();
    check("t4_full", 128'(disp_ready), 128'(0));
    drive_disp(4'h5, 6'd14, 1'b1, '0, 32'h55, 1'b1, '0, 32'h66);
    tick(); idle();
    check("t4_still_full", 128'(disp_ready), 128'(0));
    check("t4_no_issue", 128'(iss_valid), 128'(0));
    drive_cdb(6'd40, 32'h40);
    push_exp(4'h4, 6'd10, 32'h40, 32'd0);
    tick(); idle();
    check("t4_full_at_wake", 128'(disp_ready), 128'(0));
    tick();
    check("t4_iss_dst", 128'(iss_dst_tag), 128'(10));
    check("t4_slot_free", 128'(disp_ready), 128'(1));
    for (int k = 1; k < 4; k++) begin
      drive_cdb(TAG_W'(40 + k), DATA_W'(32'h40 + k));
      push_exp(4'h4, TAG_W'(10 + k), DATA_W'(32'h40 + k), DATA_W'(k));
      tick(); idle();
    end
    wait_drain(20);

    // 5: B (higher index) older than A; both woken together -> B first
    drive_disp(4'h6, 6'd20, 1'b0, 6'd30, '0, 1'b1, '0, 32'hA0);
    tick();
    drive_disp(4'h6, 6'd21, 1'b0, 6'd31, '0, 1'b1, '0, 32'hB1);
    tick(); idle();
    drive_cdb(6'd30, 32'h30);
    push_exp(4'h6, 6'd20, 32'h30, 32'hA0);
    tick(); idle();
    tick(); tick();
    drive_disp(4'h7, 6'd22, 1'b0, 6'd31, '0, 1'b1, '0, 32'hC2);
    tick(); idle();
    drive_cdb(6'd31, 32'h31);
    push_exp(4'h6, 6'd21, 32'h31, 32'hB1);
    push_exp(4'h7, 6'd22, 32'h31, 32'hC2);
    tick(); idle();
    tick();
    check("t5_first_B", 128'(iss_dst_tag), 128'(21));
    tick();
    check("t5_then_A", 128'(iss_dst_tag), 128'(22));
    wait_drain(20);

    // 6: stalled issue slot holds; flush mid-stall clears everything
    alu_stall = 1'b1;
    drive_disp(4'h8, 6'd30, 1'b1, '0, 32'h11, 1'b1, '0, 32'h22);
    tick(); idle();
    check("t6_iss_valid", 128'(iss_valid), 128'(1));
    drive_disp(4'h9, 6'd31, 1'b1, '0, 32'h33, 1'b1, '0, 32'h44);
    tick(); idle();
    for (int k = 0; k < 3; k++) begin
      check("t6_hold", {iss_valid, iss_op, iss_dst_tag, iss_a, iss_b},
            {1'b1, 4'h8, 6'd30, 32'h11, 32'h22});
      tick();
    end
    check("t6_ready_during_stall", 128'(disp_ready), 128'(1));
    flush = 1'b1;
    tick(); idle();
    check("t6_flush_iss", 128'(iss_valid), 128'(0));
    check("t6_flush_ready", 128'(disp_ready), 128'(1));
    alu_stall = 1'b0;
    tick(); tick();
    check("t6_flushed_entry", 128'(iss_valid), 128'(0));

    check("sb_empty", 128'(sb_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
